hello: RTL and testbench



---
 rtl/hello_pkg.sv | 33 +++
 rtl/hello_jk_ff_cell.sv | 33 +++
 rtl/hello.sv | 53 +++++
 tb/tb_hello.sv | 131 +++++++++++++
 4 files changed

// File: rtl/hello_pkg.sv
// Shared definitions for the hello modulo-N counter.
//   DEF_WIDTH / DEF_MODULUS : default counter width and sequence length
//   TERMINAL                : last count value of the default sequence
//   jk_op_e / jk_next       : JK flip-flop action encoding and next-state helper
package hello_pkg;

  localparam int unsigned DEF_WIDTH   = 5;
  localparam int unsigned DEF_MODULUS = 20;
  localparam int unsigned TERMINAL    = DEF_MODULUS - 1;

  // Encoding matches the {j, k} input pair.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    jk_op_e op;
    logic   nxt;
    op = jk_op_e'({j, k});
    case (op)
      JK_HOLD: nxt = q;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TOG:  nxt = ~q;
      default: nxt = 1'b0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hello_jk_ff_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset.
//   clk   : rising-edge clock
//   reset : synchronous clear, priority over j/k
//   j, k  : JK control inputs
//   q     : stored bit
module jk_ff_cell
  import hello_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = jk_next(q_q, j, k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hello.sv
// Free-running synchronous modulo-MODULUS up-counter built from JK cells.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   q     : current count, 0 .. MODULUS-1
//   flag  : high while q == MODULUS-1
module hello
  import hello_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic             flag
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             clear;

  // Ripple-carry toggle enables: bit i toggles when all lower bits are 1.
  // At the terminal value, or any value above it, every cell is cleared so
  // the counter wraps and self-corrects out-of-range states to 0.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & cnt[i-1];
    end
    clear = (cnt >= LAST);
    j     = clear ? '0 : carry;
    k     = clear ? '1 : carry;
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[b]),
      .k     (k[b]),
      .q     (cnt[b])
    );
  end

  assign q    = cnt;
  assign flag = (cnt == LAST);

endmodule

// File: tb/tb_hello.sv
module tb_hello;

  logic       clk;
  logic       reset;
  logic [4:0] q0, q32, q2;
  logic       f0, f32, f2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0] q0;
    logic       f0;
    logic [4:0] q32;
    logic       f32;
    logic [4:0] q2;
    logic       f2;
  } exp_t;

  typedef struct {
    logic rst;
    int   n;
  } seg_t;

  exp_t sb[$];
  int   rise_t[$];
  bit   stim_done = 0;

  hello dut0 (.clk(clk), .reset(reset), .q(q0), .flag(f0));
  hello #(.WIDTH(5), .MODULUS(32)) dut32 (.clk(clk), .reset(reset), .q(q32), .flag(f32));
  hello #(.WIDTH(5), .MODULUS(2))  dut2  (.clk(clk), .reset(reset), .q(q2), .flag(f2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] nxt(input logic [4:0] cur, input int unsigned m, input logic r);
    logic [4:0] res;
    if (r) res = 5'd0;
    else if (cur == 5'(m - 1)) res = 5'd0;
    else res = 5'(cur + 5'd1);
    return res;
  endfunction

  // Stimulus: reset value per edge, expected post-edge state pushed before the edge.
  initial begin
    seg_t segs[8];
    logic [4:0] m0, m32, m2;
    exp_t e;
    bit first;
    segs[0] = '{1'b1, 1};   // reset across first edge (5 ns)
    segs[1] = '{1'b0, 41};  // count through two flag pulses and a 32-wrap
    segs[2] = '{1'b1, 3};   // reset held: q stays 0
    segs[3] = '{1'b0, 7};   // count to 7
    segs[4] = '{1'b1, 1};   // reset while q == 7
    segs[5] = '{1'b0, 19};  // count to 19
    segs[6] = '{1'b1, 1};   // reset at terminal count
    segs[7] = '{1'b0, 5};   // resume 1, 2, ...
    m0 = '0; m32 = '0; m2 = '0;
    first = 1;
    reset = 1'b1;
    foreach (segs[s]) begin
      for (int n = 0; n < segs[s].n; n++) begin
        if (!first) @(negedge clk);
        first = 0;
        reset = segs[s].rst;
        m0  = nxt(m0, 20, segs[s].rst);
        m32 = nxt(m32, 32, segs[s].rst);
        m2  = nxt(m2, 2, segs[s].rst);
        e.q0 = m0;   e.f0 = (m0 == 5'd19);
        e.q32 = m32; e.f32 = (m32 == 5'd31);
        e.q2 = m2;   e.f2 = (m2 == 5'd1);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    stim_done = 1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("flag_pulse_count_ge2", int'(rise_t.size() >= 2), 1);
    if (rise_t.size() >= 2) begin
      chk("first_flag_time", rise_t[0], 195);
      chk("second_flag_time", rise_t[1], 395);
      chk("flag_period", rise_t[1] - rise_t[0], 200);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: pops one expectation per rising edge and compares all three DUTs.
  initial begin
    exp_t e;
    logic [4:0] held;
    logic       prev_f0;
    prev_f0 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!stim_done && sb.size() != 0) begin
        e = sb.pop_front();
        chk("q_mod20",   int'(q0),  int'(e.q0));
        chk("flag_mod20", int'(f0), int'(e.f0));
        chk("q_mod32",   int'(q32), int'(e.q32));
        chk("flag_mod32", int'(f32), int'(e.f32));
        chk("q_mod2",    int'(q2),  int'(e.q2));
        chk("flag_mod2", int'(f2),  int'(e.f2));
        if (f0 && !prev_f0) rise_t.push_back(int'($time) - 1);
        prev_f0 = f0;
        held = q0;
        @(negedge clk);
        #1;
        chk("q_holds_between_edges", int'(q0), int'(held));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
